elevator_req_sched: RTL and testbench

Request scheduler that sits directly upstream of the elevator motion controller. It collects hall calls and in-cab floor selections into a pending-request bitmap. It picks the next target floor using a SCAN (keep-direction) policy and drives the controller's destination input. It also owns door control, so the door opens only while the car is parked at a floor and never during an emergency.

---
 rtl/elevator_pkg.sv | 23 ++
 rtl/elevator_pick.sv | 72 +++++++
 rtl/elevator_req_sched.sv | 155 +++++++++++++++
 tb/tb_elevator_req_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator request scheduler and the
// motion stage downstream of it.
package elevator_pkg;

    localparam int unsigned N_FLOORS_DEF = 10;
    localparam int unsigned FLOOR_W_DEF  = 4;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        DOOR,
        EMER
    } sched_state_t;

    // Motion-controller states, shared with the motion stage
    typedef enum logic [1:0] {
        MOT_STOP,
        MOT_UP,
        MOT_DOWN
    } motion_state_t;

endpackage

// File: rtl/elevator_pick.sv
// Combinational SCAN target picker. Keeps the current direction while a
// pending floor lies ahead. Otherwise it turns around toward the nearest
// pending floor behind the car. The current floor itself is never chosen.
module elevator_pick
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS = N_FLOORS_DEF,
    parameter int unsigned FLOOR_W  = FLOOR_W_DEF
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  cur,
    input  logic                dir_up,
    output logic                valid,
    output logic [FLOOR_W-1:0]  target,
    output logic                next_dir_up
);

    logic                above_ok;
    logic                below_ok;
    logic [FLOOR_W-1:0]  above;
    logic [FLOOR_W-1:0]  below;
    int unsigned         cur_u;

    assign cur_u = 32'(cur);

    // Nearest pending floor above (descending scan) and below (ascending scan)
    always_comb begin
        above_ok = 1'b0;
        below_ok = 1'b0;
        above    = '0;
        below    = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending[N_FLOORS-1-i] && ((N_FLOORS - 1 - i) > cur_u)) begin
                above_ok = 1'b1;
                above    = FLOOR_W'(N_FLOORS - 1 - i);
            end
            if (pending[i] && (i < cur_u)) begin
                below_ok = 1'b1;
                below    = FLOOR_W'(i);
            end
        end
    end

    // Direction-preferring selection with turnaround
    always_comb begin
        valid       = 1'b0;
        target      = '0;
        next_dir_up = dir_up;
        if (dir_up) begin
            if (above_ok) begin
                valid       = 1'b1;
                target      = above;
                next_dir_up = 1'b1;
            end else if (below_ok) begin
                valid       = 1'b1;
                target      = below;
                next_dir_up = 1'b0;
            end
        end else begin
            if (below_ok) begin
                valid       = 1'b1;
                target      = below;
                next_dir_up = 1'b0;
            end else if (above_ok) begin
                valid       = 1'b1;
                target      = above;
                next_dir_up = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_req_sched.sv
// Elevator request scheduler. Collects hall and cab requests into a pending
// bitmap. Picks SCAN targets for the motion controller and owns the door,
// which opens only while the car is parked at the destination floor.
module elevator_req_sched
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS    = N_FLOORS_DEF,
    parameter int unsigned FLOOR_W     = FLOOR_W_DEF,
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_FLOORS-1:0] I_HALL_REQ,
    input  logic                I_CAB_VALID,
    input  logic [FLOOR_W-1:0]  I_CAB_FLOOR,
    input  logic [FLOOR_W-1:0]  I_CUR_FLOOR,
    input  logic                I_EMERGENCY,
    input  logic                I_EMER_RESOLVE,
    output logic [FLOOR_W-1:0]  O_DEST_FLOOR,
    output logic                O_DOOR_OPEN,
    output logic                O_DIR_UP,
    output logic [N_FLOORS-1:0] O_PENDING
);

    localparam int unsigned     CNT_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    sched_state_t        state;
    sched_state_t        state_next;
    logic [N_FLOORS-1:0] pending;
    logic [N_FLOORS-1:0] pending_next;
    logic [FLOOR_W-1:0]  dest_q;
    logic [FLOOR_W-1:0]  dest_next;
    logic                dir_q;
    logic                dir_next;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_next;
    logic                enter_door;

    logic [N_FLOORS-1:0] cab_oh;
    logic [N_FLOORS-1:0] cur_oh;
    logic [N_FLOORS-1:0] req_set;

    logic                pick_valid;
    logic [FLOOR_W-1:0]  pick_target;
    logic                pick_dir;

    elevator_pick #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_pick (
        .pending     (pending),
        .cur         (I_CUR_FLOOR),
        .dir_up      (dir_q),
        .valid       (pick_valid),
        .target      (pick_target),
        .next_dir_up (pick_dir)
    );

    // Out-of-range floor indices decode to an all-zero one-hot
    always_comb begin
        cab_oh = '0;
        cur_oh = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            cab_oh[i] = I_CAB_VALID && (32'(I_CAB_FLOOR) == i);
            cur_oh[i] = (32'(I_CUR_FLOOR) == i);
        end
    end

    assign req_set = I_HALL_REQ | cab_oh;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            pending <= '0;
            dest_q  <= '0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            dest_q  <= dest_next;
            dir_q   <= dir_next;
            cnt_q   <= cnt_next;
        end
    end

    // Next-state, target/direction latch, dwell counter and request capture
    always_comb begin
        state_next = state;
        dest_next  = dest_q;
        dir_next   = dir_q;
        cnt_next   = cnt_q;
        enter_door = 1'b0;

        case (state)
            IDLE: begin
                if (I_EMERGENCY) begin
                    state_next = EMER;
                end else if (|(pending & cur_oh)) begin
                    state_next = DOOR;
                    enter_door = 1'b1;
                end else if (pick_valid) begin
                    state_next = SERVE;
                    dest_next  = pick_target;
                    dir_next   = pick_dir;
                end
            end
            SERVE: begin
                if (I_EMERGENCY) begin
                    state_next = EMER;
                end else if (I_CUR_FLOOR == dest_q) begin
                    state_next = DOOR;
                    enter_door = 1'b1;
                end
            end
            DOOR: begin
                if (I_EMERGENCY) begin
                    state_next = EMER;
                end else if (cnt_q == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_q - CNT_W'(1);
                end
            end
            EMER: begin
                if (!I_EMERGENCY && I_EMER_RESOLVE) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (enter_door) begin
            cnt_next = CNT_LOAD;
        end

        // On the entry edge a new request for cur survives. While the door
        // is open, the open floor's bit is held clear so repeat calls vanish.
        if (state == DOOR) begin
            pending_next = (pending | req_set) & ~cur_oh;
        end else if (enter_door) begin
            pending_next = (pending & ~cur_oh) | req_set;
        end else begin
            pending_next = pending | req_set;
        end
    end

    assign O_DEST_FLOOR = (state == SERVE) ? dest_q : I_CUR_FLOOR;
    assign O_DOOR_OPEN  = (state == DOOR);
    assign O_DIR_UP     = dir_q;
    assign O_PENDING    = pending;

endmodule

// File: tb/tb_elevator_req_sched.sv
// Self-checking bench for elevator_req_sched (10 floors, 4-cycle dwell).
// Table vectors are driven on the falling edge. Each expected record goes
// into a scoreboard queue and is compared just after the following rising
// edge. A short car-model sequence then follows.
module tb_elevator_req_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] hall;
    logic       cab_v;
    logic [3:0] cab_f;
    logic [3:0] cur;
    logic       emer;
    logic       res;
    logic [3:0] dest;
    logic       door;
    logic       dir_up;
    logic [9:0] pend;

    int n_vec  = 0;
    int n_miss = 0;

    elevator_req_sched #(
        .N_FLOORS    (10),
        .FLOOR_W     (4),
        .DOOR_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .I_HALL_REQ     (hall),
        .I_CAB_VALID    (cab_v),
        .I_CAB_FLOOR    (cab_f),
        .I_CUR_FLOOR    (cur),
        .I_EMERGENCY    (emer),
        .I_EMER_RESOLVE (res),
        .O_DEST_FLOOR   (dest),
        .O_DOOR_OPEN    (door),
        .O_DIR_UP       (dir_up),
        .O_PENDING      (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic [9:0] hall;
        logic       cab_v;
        logic [3:0] cab_f;
        logic [3:0] cur;
        logic       emer;
        logic       res;
        logic [3:0] e_dest;
        logic       e_door;
        logic       e_up;
        logic [9:0] e_pend;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] dest;
        logic       door;
        logic       up;
        logic [9:0] pend;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input int n, input logic r, input logic [9:0] h,
                       input logic cv, input logic [3:0] cf, input logic [3:0] c,
                       input logic e, input logic rs, input logic [3:0] d,
                       input logic dr, input logic up, input logic [9:0] p);
        vec_t t;
        t.rstn = r;  t.hall = h;  t.cab_v = cv; t.cab_f = cf; t.cur = c;
        t.emer = e;  t.res = rs;  t.e_dest = d; t.e_door = dr;
        t.e_up = up; t.e_pend = p;
        for (int k = 0; k < n; k++) vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        exp_t e;
        bit   door_seen;
        int   dwell;
        bit   closed;

        rstn = 1'b0; hall = '0; cab_v = 1'b0; cab_f = '0;
        cur = '0; emer = 1'b0; res = 1'b0;

        //   n  rstn hall     cv cf  cur em rs  dest door up pend
        // reset, then hall call at 5 from floor 0
        add(1, 0, 10'h000, 0, 0,  0, 0, 0,  0, 0, 1, 10'h000);
        add(1, 1, 10'h020, 0, 0,  0, 0, 0,  0, 0, 1, 10'h020);
        add(1, 1, 10'h000, 0, 0,  0, 0, 0,  5, 0, 1, 10'h020);
        add(1, 1, 10'h000, 0, 0,  3, 0, 0,  5, 0, 1, 10'h020);
        add(4, 1, 10'h000, 0, 0,  5, 0, 0,  5, 1, 1, 10'h000);
        add(1, 1, 10'h000, 0, 0,  5, 0, 0,  5, 0, 1, 10'h000);
        // cur 4 going up, pending {2,7}: 7 first, then turn down to 2
        add(1, 1, 10'h084, 0, 0,  4, 0, 0,  4, 0, 1, 10'h084);
        add(1, 1, 10'h000, 0, 0,  4, 0, 0,  7, 0, 1, 10'h084);
        add(4, 1, 10'h000, 0, 0,  7, 0, 0,  7, 1, 1, 10'h004);
        add(1, 1, 10'h000, 0, 0,  7, 0, 0,  7, 0, 1, 10'h004);
        add(1, 1, 10'h000, 0, 0,  7, 0, 0,  2, 0, 0, 10'h004);
        add(4, 1, 10'h000, 0, 0,  2, 0, 0,  2, 1, 0, 10'h000);
        add(1, 1, 10'h000, 0, 0,  2, 0, 0,  2, 0, 0, 10'h000);
        // cab select at the current floor; repeat hall calls during dwell
        add(1, 1, 10'h000, 1, 3,  3, 0, 0,  3, 0, 0, 10'h008);
        add(1, 1, 10'h000, 0, 0,  3, 0, 0,  3, 1, 0, 10'h000);
        add(3, 1, 10'h008, 0, 0,  3, 0, 0,  3, 1, 0, 10'h000);
        add(1, 1, 10'h000, 0, 0,  3, 0, 0,  3, 0, 0, 10'h000);
        // heading to 8, emergency, cab 1 during EMER, resolve, serve 8 then 1
        add(1, 1, 10'h100, 0, 0,  3, 0, 0,  3, 0, 0, 10'h100);
        add(1, 1, 10'h000, 0, 0,  3, 0, 0,  8, 0, 1, 10'h100);
        add(1, 1, 10'h000, 0, 0,  4, 0, 0,  8, 0, 1, 10'h100);
        add(1, 1, 10'h000, 0, 0,  5, 1, 0,  5, 0, 1, 10'h100);
        add(1, 1, 10'h000, 1, 1,  5, 0, 0,  5, 0, 1, 10'h102);
        add(1, 1, 10'h000, 0, 0,  5, 0, 1,  5, 0, 1, 10'h102);
        add(1, 1, 10'h000, 0, 0,  5, 0, 0,  8, 0, 1, 10'h102);
        add(4, 1, 10'h000, 0, 0,  8, 0, 0,  8, 1, 1, 10'h002);
        add(1, 1, 10'h000, 0, 0,  8, 0, 0,  8, 0, 1, 10'h002);
        add(1, 1, 10'h000, 0, 0,  8, 0, 0,  1, 0, 0, 10'h002);
        add(4, 1, 10'h000, 0, 0,  1, 0, 0,  1, 1, 0, 10'h000);
        add(1, 1, 10'h000, 0, 0,  1, 0, 0,  1, 0, 0, 10'h000);
        // out-of-range cab floors; emergency and resolve together
        add(1, 1, 10'h000, 1, 12, 1, 0, 0,  1, 0, 0, 10'h000);
        add(1, 1, 10'h000, 1, 10, 1, 0, 0,  1, 0, 0, 10'h000);
        add(1, 1, 10'h000, 0, 0,  1, 1, 0,  1, 0, 0, 10'h000);
        add(1, 1, 10'h040, 0, 0,  1, 1, 1,  1, 0, 0, 10'h040);
        add(1, 1, 10'h000, 0, 0,  1, 1, 1,  1, 0, 0, 10'h040);
        add(1, 1, 10'h000, 0, 0,  1, 0, 1,  1, 0, 0, 10'h040);
        add(1, 1, 10'h000, 0, 0,  1, 0, 0,  6, 0, 1, 10'h040);
        // emergency in the second door cycle
        add(2, 1, 10'h000, 0, 0,  6, 0, 0,  6, 1, 1, 10'h000);
        add(1, 1, 10'h000, 0, 0,  6, 1, 0,  6, 0, 1, 10'h000);
        add(1, 1, 10'h000, 0, 0,  6, 0, 1,  6, 0, 1, 10'h000);
        // target floor 0 (turn down), then reset mid-SERVE
        add(1, 1, 10'h001, 0, 0,  6, 0, 0,  6, 0, 1, 10'h001);
        add(1, 1, 10'h000, 0, 0,  6, 0, 0,  0, 0, 0, 10'h001);
        add(1, 1, 10'h100, 0, 0,  5, 0, 0,  0, 0, 0, 10'h101);
        add(1, 0, 10'h000, 0, 0,  4, 0, 0,  4, 0, 1, 10'h000);
        add(1, 1, 10'h000, 0, 0,  4, 0, 0,  4, 0, 1, 10'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rstn  = vecs[i].rstn;  hall = vecs[i].hall;
            cab_v = vecs[i].cab_v; cab_f = vecs[i].cab_f;
            cur   = vecs[i].cur;   emer = vecs[i].emer; res = vecs[i].res;
            e.idx  = i;
            e.dest = vecs[i].e_dest; e.door = vecs[i].e_door;
            e.up   = vecs[i].e_up;   e.pend = vecs[i].e_pend;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_vec++;
            if ({dest, door, dir_up, pend} !== {e.dest, e.door, e.up, e.pend}) begin
                n_miss++;
                $display("FAIL vec%0d: got dest=%0d door=%0b up=%0b pend=%h, want dest=%0d door=%0b up=%0b pend=%h",
                         e.idx, dest, door, dir_up, pend, e.dest, e.door, e.up, e.pend);
            end
        end

        // Car model: from floor 4, call at top floor 9; car steps one floor
        // per cycle toward the destination until the door opens.
        @(negedge clk);
        rstn = 1'b1; hall = 10'h200; cab_v = 1'b0; emer = 1'b0; res = 1'b0; cur = 4'd4;
        @(negedge clk);
        hall = '0;
        door_seen = 1'b0;
        for (int k = 0; k < 40 && !door_seen; k++) begin
            @(posedge clk);
            #1;
            if (door) begin
                door_seen = 1'b1;
            end else begin
                @(negedge clk);
                if (dest > cur) cur = cur + 4'd1;
                else if (dest < cur) cur = cur - 4'd1;
            end
        end
        chk("car_door_seen", int'(door_seen), 1);
        chk("car_arrive_floor", int'(cur), 9);
        chk("car_arrive_pend", int'(pend), 0);
        chk("car_dir_up", int'(dir_up), 1);
        dwell  = door_seen ? 1 : 0;
        closed = 1'b0;
        for (int k = 0; k < 20 && door_seen && !closed; k++) begin
            @(posedge clk);
            #1;
            if (door) dwell++;
            else closed = 1'b1;
        end
        chk("car_dwell", dwell, 4);
        chk("car_dest_parked", int'(dest), 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
